// File: rtl/alu_flags_reg.sv
// Registered ALU condition flags (C/N/Z/V) with a sticky overflow flag, a
// saturating overflow-event counter and a condition-code evaluator.
module alu_flags_reg #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 8,
    parameter bit LOGIC_KEEP_CV = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] result,
    input  logic             co_add,
    input  logic             co_prev_add,
    input  logic             co_sub,
    input  logic             co_prev_sub,
    input  logic             flag_we,
    input  logic             sv_clr,
    input  logic [3:0]       cond,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             sv,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             out_valid,
    output logic             cond_true
);

    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;

    logic nc, nn, nz, nv;
    logic is_arith;
    logic load;
    logic ovf_event;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        nn       = result[WIDTH-1];
        nz       = (result == '0);
        nc       = LOGIC_KEEP_CV ? c : 1'b0;
        nv       = LOGIC_KEEP_CV ? v : 1'b0;
        is_arith = 1'b0;
        case (op)
            OP_ADD: begin
                nc       = co_add;
                nv       = co_add ^ co_prev_add;
                is_arith = 1'b1;
            end
            OP_SUB: begin
                nc       = co_sub;
                nv       = co_sub ^ co_prev_sub;
                is_arith = 1'b1;
            end
            default: ;
        endcase
    end

    assign load      = in_valid & flag_we;
    assign ovf_event = load & is_arith & nv;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b1;
            v         <= 1'b0;
            sv        <= 1'b0;
            ovf_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (load) begin
                c <= nc;
                n <= nn;
                z <= nz;
                v <= nv;
            end
            // An overflow event outranks a simultaneous clear: count restarts at 1.
            if (ovf_event) begin
                sv <= 1'b1;
                if (sv_clr)
                    ovf_cnt <= CNT_W'(1);
                else if (ovf_cnt != '1)
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
            end else if (sv_clr) begin
                sv      <= 1'b0;
                ovf_cnt <= '0;
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            CC_EQ: cond_true = z;
            CC_NE: cond_true = ~z;
            CC_CS: cond_true = c;
            CC_CC: cond_true = ~c;
            CC_MI: cond_true = n;
            CC_PL: cond_true = ~n;
            CC_VS: cond_true = v;
            CC_VC: cond_true = ~v;
            CC_HI: cond_true = c & ~z;
            CC_LS: cond_true = ~c | z;
            CC_GE: cond_true = (n == v);
            CC_LT: cond_true = (n != v);
            CC_GT: cond_true = ~z & (n == v);
            CC_LE: cond_true = z | (n != v);
            CC_AL: cond_true = 1'b1;
            CC_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_flags_reg.sv
// Bench for alu_flags_reg: two instances (CNT_W=2/clear C,V and CNT_W=3/keep C,V)
// share stimulus and are checked each cycle against an operand-level flag model.
module tb_alu_flags_reg;

    logic        clk = 1'b0;
    logic        reset, in_valid, flag_we, sv_clr;
    logic [2:0]  op;
    logic [31:0] result;
    logic        co_add, co_prev_add, co_sub, co_prev_sub;
    logic [3:0]  cond;

    // Architectural C and V the operands imply, used by the model for ADD/SUB.
    logic        exp_nc, exp_nv;

    logic        a_c, a_n, a_z, a_v, a_sv, a_ov, a_ct;
    logic [1:0]  a_cnt;
    logic        b_c, b_n, b_z, b_v, b_sv, b_ov, b_ct;
    logic [2:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_flags_reg #(.WIDTH(32), .CNT_W(2), .LOGIC_KEEP_CV(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .result(result),
        .co_add(co_add), .co_prev_add(co_prev_add), .co_sub(co_sub), .co_prev_sub(co_prev_sub),
        .flag_we(flag_we), .sv_clr(sv_clr), .cond(cond),
        .c(a_c), .n(a_n), .z(a_z), .v(a_v), .sv(a_sv), .ovf_cnt(a_cnt),
        .out_valid(a_ov), .cond_true(a_ct)
    );

    alu_flags_reg #(.WIDTH(32), .CNT_W(3), .LOGIC_KEEP_CV(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .result(result),
        .co_add(co_add), .co_prev_add(co_prev_add), .co_sub(co_sub), .co_prev_sub(co_prev_sub),
        .flag_we(flag_we), .sv_clr(sv_clr), .cond(cond),
        .c(b_c), .n(b_n), .z(b_z), .v(b_v), .sv(b_sv), .ovf_cnt(b_cnt),
        .out_valid(b_ov), .cond_true(b_ct)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic m_c [2], m_n [2], m_z [2], m_v [2], m_sv [2];
    int   m_cnt [2];
    logic m_ov;

    function automatic int cnt_max(input int i);
        return (i == 0) ? 3 : 7;
    endfunction

    function automatic logic cond_eval(input logic [3:0] sel, input logic fc, fn, fz, fv);
        logic ge;
        ge = (fn == fv);
        case (sel)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return !fz && ge;
            4'd13: return fz || !ge;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic arith, ev;
        arith = (op == 3'b110) || (op == 3'b111);
        if (reset) begin
            m_ov = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_c[i] = 1'b0; m_n[i] = 1'b0; m_z[i] = 1'b1; m_v[i] = 1'b0;
                m_sv[i] = 1'b0; m_cnt[i] = 0;
            end
        end else begin
            m_ov = in_valid;
            for (int i = 0; i < 2; i++) begin
                ev = 1'b0;
                if (in_valid && flag_we) begin
                    m_n[i] = result[31];
                    m_z[i] = (result == 32'd0);
                    if (arith) begin
                        m_c[i] = exp_nc;
                        m_v[i] = exp_nv;
                        ev     = exp_nv;
                    end else if (i == 0) begin
                        m_c[i] = 1'b0;
                        m_v[i] = 1'b0;
                    end
                end
                if (ev) begin
                    m_sv[i]  = 1'b1;
                    m_cnt[i] = sv_clr ? 1 : ((m_cnt[i] < cnt_max(i)) ? m_cnt[i] + 1 : m_cnt[i]);
                end else if (sv_clr) begin
                    m_sv[i]  = 1'b0;
                    m_cnt[i] = 0;
                end
            end
        end
    end

    task automatic compare_inst(input int i, input logic c_, n_, z_, v_, sv_, ov_, ct_,
                                input logic [7:0] cnt_);
        string p;
        p = (i == 0) ? "a" : "b";
        check1({p, ".c"}, c_, m_c[i]);
        check1({p, ".n"}, n_, m_n[i]);
        check1({p, ".z"}, z_, m_z[i]);
        check1({p, ".v"}, v_, m_v[i]);
        check1({p, ".sv"}, sv_, m_sv[i]);
        check1({p, ".out_valid"}, ov_, m_ov);
        check1({p, ".cond_true"}, ct_, cond_eval(cond, m_c[i], m_n[i], m_z[i], m_v[i]));
        checkn({p, ".ovf_cnt"}, cnt_, 8'(m_cnt[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_inst(0, a_c, a_n, a_z, a_v, a_sv, a_ov, a_ct, 8'(a_cnt));
            compare_inst(1, b_c, b_n, b_z, b_v, b_sv, b_ov, b_ct, 8'(b_cnt));
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic apply(input logic rst, iv, we, clr, input logic [2:0] o, input logic [31:0] r,
                         input logic ca, cpa, cs, cps, enc, env);
        reset = rst; in_valid = iv; flag_we = we; sv_clr = clr; op = o; result = r;
        co_add = ca; co_prev_add = cpa; co_sub = cs; co_prev_sub = cps;
        exp_nc = enc; exp_nv = env;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cond(input logic [3:0] s);
        cond = s;
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_cycle();
        logic [31:0] a, b, r;
        logic [32:0] s;
        logic [31:0] lo;
        logic [2:0]  o;
        logic        ca, cpa, cs, cps, enc, env;
        a = pick(); b = pick();
        ca = 1'($urandom); cpa = 1'($urandom); cs = 1'($urandom); cps = 1'($urandom);
        enc = 1'b0; env = 1'b0;
        case ($urandom_range(0, 3))
            0: o = 3'b110;
            1: o = 3'b111;
            default: o = 3'($urandom_range(0, 5));
        endcase
        if (o == 3'b110) begin
            s   = {1'b0, a} + {1'b0, b};
            r   = a + b;
            lo  = {1'b0, a[30:0]} + {1'b0, b[30:0]};
            ca  = s[32];
            cpa = lo[31];
            enc = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            env = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (o == 3'b111) begin
            s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r   = a - b;
            lo  = {1'b0, ~b[30:0]} + {1'b0, a[30:0]} + 32'd1;
            cs  = s[32];
            cps = lo[31];
            enc = (a >= b);
            env = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            case ($urandom_range(0, 3))
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                default: r = 32'd0;
            endcase
        end
        cond = 4'($urandom_range(0, 15));
        apply(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 8),
              1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 19) == 0),
              o, r, ca, cpa, cs, cps, enc, env);
    endtask

    int sat_a [5] = '{1, 2, 3, 3, 3};

    initial begin
        cond = 4'd0;
        // Reset together with a valid overflowing ADD and a clear: reset wins.
        apply(1, 1, 1, 1, 3'b110, 32'h8000_0000, 0, 1, 0, 0, 0, 1);
        chk_en = 1'b1;
        check1("rst.a.c", a_c, 1'b0);   check1("rst.a.z", a_z, 1'b1);
        check1("rst.a.n", a_n, 1'b0);   check1("rst.a.v", a_v, 1'b0);
        check1("rst.a.sv", a_sv, 1'b0); checkn("rst.a.cnt", 8'(a_cnt), 8'd0);
        check1("rst.a.ov", a_ov, 1'b0); check1("rst.b.z", b_z, 1'b1);
        set_cond(4'd0); check1("rst.EQ", a_ct, 1'b1);
        set_cond(4'd1); check1("rst.NE", a_ct, 1'b0);
        apply(0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0, 0, 0);
        check1("rst.no_pulse.a", a_ov, 1'b0);
        check1("rst.no_pulse.b", b_ov, 1'b0);

        // ADD 0 with carry in and out of MSB: C=1, Z=1, V=0.
        apply(0, 1, 1, 0, 3'b110, 32'h0000_0000, 1, 1, 0, 0, 1, 0);
        check1("add.c", a_c, 1'b1); check1("add.z", a_z, 1'b1);
        check1("add.n", a_n, 1'b0); check1("add.v", a_v, 1'b0);
        check1("add.ov", a_ov, 1'b1);
        set_cond(4'd0); check1("add.EQ", a_ct, 1'b1);

        // SUB overflow to 0x80000000; adder carries deliberately disagree.
        apply(0, 1, 1, 0, 3'b111, 32'h8000_0000, 1, 1, 0, 1, 0, 1);
        check1("sub.v", a_v, 1'b1); check1("sub.n", a_n, 1'b1);
        check1("sub.c", a_c, 1'b0); check1("sub.sv", a_sv, 1'b1);
        checkn("sub.cnt", 8'(a_cnt), 8'd1);
        set_cond(4'd11); check1("sub.LT", a_ct, 1'b0);
        set_cond(4'd6);  check1("sub.VS", a_ct, 1'b1);

        // Clear with in_valid low: the ADD overflow must not count.
        apply(0, 0, 1, 1, 3'b110, 32'h8000_0000, 0, 1, 0, 0, 0, 1);
        checkn("clr.a.cnt", 8'(a_cnt), 8'd0); check1("clr.a.sv", a_sv, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply(0, 1, 1, 0, 3'b110, 32'h8000_0000, 0, 1, 0, 0, 0, 1);
            checkn($sformatf("sat.a.cnt%0d", k), 8'(a_cnt), 8'(sat_a[k]));
            checkn($sformatf("sat.b.cnt%0d", k), 8'(b_cnt), 8'(k + 1));
        end
        apply(0, 1, 1, 1, 3'b010, 32'h0000_0005, 0, 0, 0, 0, 0, 0);
        checkn("clr2.a.cnt", 8'(a_cnt), 8'd0); check1("clr2.a.sv", a_sv, 1'b0);
        checkn("clr2.b.cnt", 8'(b_cnt), 8'd0);
        apply(0, 1, 1, 1, 3'b110, 32'h8000_0000, 0, 1, 0, 0, 0, 1);
        checkn("clrev.a.cnt", 8'(a_cnt), 8'd1); check1("clrev.a.sv", a_sv, 1'b1);
        checkn("clrev.b.cnt", 8'(b_cnt), 8'd1);

        // ADD setting C and V, then a logic op: a clears C/V, b keeps them.
        apply(0, 1, 1, 0, 3'b110, 32'h7FFF_FFFF, 1, 0, 0, 0, 1, 1);
        check1("addcv.c", a_c, 1'b1); check1("addcv.v", a_v, 1'b1);
        apply(0, 1, 1, 0, 3'b010, 32'h0000_0005, 1, 1, 1, 1, 0, 0);
        check1("logic.a.c", a_c, 1'b0); check1("logic.a.v", a_v, 1'b0);
        check1("logic.b.c", b_c, 1'b1); check1("logic.b.v", b_v, 1'b1);
        check1("logic.a.n", a_n, 1'b0); check1("logic.a.z", a_z, 1'b0);
        check1("logic.b.n", b_n, 1'b0); check1("logic.b.z", b_z, 1'b0);

        // in_valid without flag_we: pulse only, flags hold.
        apply(0, 1, 0, 0, 3'b110, 32'h0000_0000, 1, 1, 0, 0, 1, 0);
        check1("nowe.ov", a_ov, 1'b1); check1("nowe.a.z", a_z, 1'b0);
        check1("nowe.a.c", a_c, 1'b0); check1("nowe.b.c", b_c, 1'b1);
        check1("nowe.b.v", b_v, 1'b1);

        // Reset mid-run with a valid op in the same cycle.
        apply(1, 1, 1, 0, 3'b111, 32'h8000_0000, 0, 0, 0, 1, 0, 1);
        check1("rst2.a.z", a_z, 1'b1); check1("rst2.b.c", b_c, 1'b0);
        check1("rst2.b.v", b_v, 1'b0); check1("rst2.b.sv", b_sv, 1'b0);
        checkn("rst2.b.cnt", 8'(b_cnt), 8'd0); check1("rst2.ov", a_ov, 1'b0);
        apply(0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0, 0, 0);
        check1("rst2.no_pulse", a_ov, 1'b0);

        for (int k = 0; k < 3000; k++)
            random_cycle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
